comparator_search: RTL
======================

// Module: comparator_search
// PURPOSE
//   Successive-approximation search engine on the consuming side of an eq/gt/lt
//   magnitude comparator. Drives candidate B values MSB-first and reads the
//   comparator's eq/gt/lt flags against a hidden operand A. Recovers A in at
//   most WIDTH probes.
//   Used for threshold discovery and self-test of the comparator datapath.
// PARAMETERS
//   WIDTH    4  operand width in bits; must be >= 1
//   CMP_LAT  0  cycles from cand change to valid flags; 0 = combinational comparator
// PORTS
//   clk      in   1      clock; everything is on the rising edge
//   rst      in   1      synchronous reset, active-high
//   start    in   1      begin a search; sampled only in IDLE
//   cmp_eq   in   1      comparator result A == cand
//   cmp_gt   in   1      comparator result A >  cand
//   cmp_lt   in   1      comparator result A <  cand
//   cand     out  WIDTH  candidate value driven to the comparator's B input
//   busy     out  1      high from the cycle after start is accepted until done
//   done     out  1      one-cycle pulse: search complete
//   found    out  WIDTH  recovered A; valid from done until the next accepted start
//   err      out  1      flags were not one-hot at a sample; valid with done
// BEHAVIOUR
//   Reset: cand=0, busy=0, done=0, found=0, err=0; FSM enters IDLE.
//     rst mid-search aborts on the same edge. No done pulse is produced.
//   States: IDLE -> PROBE -> DONE -> IDLE.
//   IDLE: busy=0. start=1 loads the following and moves to PROBE:
//     idx=WIDTH-1, res=0, cand=1<<(WIDTH-1), wait=CMP_LAT, err=0.
//     found holds its last value until this load.
//   PROBE: busy=1.
//     If wait!=0: decrement wait; flags are ignored.
//     If wait==0: sample flags.
//       Not exactly one flag high: err=1, found=0, go to DONE.
//       cmp_eq: found=cand, go to DONE (early exit).
//       cmp_gt: res=cand (keep trial bit).
//       cmp_lt: res unchanged (drop trial bit).
//       If idx==0: found = updated res, go to DONE.
//       Else: idx-=1, cand = res_new | (1<<idx_new), wait=CMP_LAT.
//   DONE: done=1 for exactly one cycle, busy=0, then IDLE.
//     cand holds its last value.
//   Handshake rules:
//     start is ignored while busy or done is high. No queueing.
//     start held high re-triggers a new search on the first IDLE cycle after DONE.
//   Timing:
//     cand changes only on the edge that begins a probe.
//     Flags are sampled exactly CMP_LAT cycles after each cand change.
//     Latency from start edge to done: worst case WIDTH*(CMP_LAT+1)+1 cycles;
//     best case (eq on first probe) CMP_LAT+2.
//   Arithmetic: all arithmetic is unsigned WIDTH-bit; no wrap is possible.
//   Boundaries: A=0 resolves through all-lt probes; A=2^WIDTH-1 resolves via eq
//     on the last probe.
// TESTING
//   W=4,L=0, A=9, start -> cand 8,12,10,9 on consecutive cycles; done with found=9, err=0.
//   W=4,L=0, A=8 -> single probe cand=8 eq; done 2 cycles after start; found=8.
//   A=0 -> cand 8,4,2,1 all lt; found=0. A=15 -> cand 8,12,14,15; found=15.
//   Flags forced gt=lt=1 on first probe -> done with err=1, found=0; next start clears err.
//   L=2, A=5: each cand held 3 cycles; rst asserted mid-search -> busy=0, no done;
//     restart finds 5.
//   Exhaustive: A=0..15 with behavioural comparator model, start held high -> every found==A.

Source files
------------

// File: rtl/comparator_search_if.sv
// comparator_search_if
//   Bundles the handshake and comparator-facing signals of the
//   successive-approximation search engine.
//   Ports (all members, WIDTH = operand width):
//     start   search request from the controlling side
//     cmp_eq  comparator flag A == cand
//     cmp_gt  comparator flag A >  cand
//     cmp_lt  comparator flag A <  cand
//     cand    candidate B value driven to the comparator
//     busy    a search is in progress
//     done    one-cycle completion pulse
//     found   recovered value of A
//     err     comparator flags were not one-hot at a sample
//   Modports: slave = search engine, master = controller/comparator side.
interface comparator_search_if #(
  parameter int WIDTH = 4
) ();
  logic             start;
  logic             cmp_eq;
  logic             cmp_gt;
  logic             cmp_lt;
  logic [WIDTH-1:0] cand;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] found;
  logic             err;

  modport slave (
    input  start, cmp_eq, cmp_gt, cmp_lt,
    output cand, busy, done, found, err
  );

  modport master (
    output start, cmp_eq, cmp_gt, cmp_lt,
    input  cand, busy, done, found, err
  );
endinterface

// File: rtl/comparator_search.sv
// comparator_search
//   Successive-approximation search engine sitting behind an eq/gt/lt
//   magnitude comparator. Probes candidate values MSB-first against a hidden
//   operand A and recovers A in at most WIDTH probes, exiting early on eq.
//   Parameters:
//     WIDTH    operand width in bits (>= 1)
//     CMP_LAT  cycles from a cand change until the flags are valid
//   Ports:
//     clk      rising-edge clock
//     rst      synchronous active-high reset; aborts a search without done
//     bus      comparator_search_if.slave (start, flags in; cand, busy,
//              done, found, err out)
module comparator_search #(
  parameter int WIDTH   = 4,
  parameter int CMP_LAT = 0
) (
  input  logic                clk,
  input  logic                rst,
  comparator_search_if.slave  bus
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int WW = (CMP_LAT > 0) ? $clog2(CMP_LAT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    PROBE,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] cand, cand_n;
  logic [WIDTH-1:0] res, res_n;
  logic [WIDTH-1:0] found, found_n;
  logic [IW-1:0]    idx, idx_n;
  logic [WW-1:0]    wait_cnt, wait_n;
  logic             err, err_n;

  // Result after folding in the current probe: a gt answer keeps the trial
  // bit (cand already holds res plus the trial bit), lt drops it.
  logic [WIDTH-1:0] res_upd;
  logic [IW-1:0]    idx_dec;

  assign res_upd = bus.cmp_gt ? cand : res;
  assign idx_dec = idx - IW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cand     <= '0;
      res      <= '0;
      found    <= '0;
      idx      <= '0;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      cand     <= cand_n;
      res      <= res_n;
      found    <= found_n;
      idx      <= idx_n;
      wait_cnt <= wait_n;
      err      <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    res_n   = res;
    found_n = found;
    idx_n   = idx;
    wait_n  = wait_cnt;
    err_n   = err;

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = PROBE;
          idx_n   = IW'(WIDTH - 1);
          res_n   = '0;
          cand_n  = WIDTH'(1) << (WIDTH - 1);
          wait_n  = WW'(CMP_LAT);
          err_n   = 1'b0;
        end
      end

      PROBE: begin
        // Flags are only trusted once the comparator latency has elapsed
        // since the last cand change.
        if (wait_cnt != '0) begin
          wait_n = wait_cnt - WW'(1);
        end else if (!$onehot({bus.cmp_eq, bus.cmp_gt, bus.cmp_lt})) begin
          err_n   = 1'b1;
          found_n = '0;
          state_n = DONE;
        end else if (bus.cmp_eq) begin
          found_n = cand;
          state_n = DONE;
        end else if (idx == '0) begin
          res_n   = res_upd;
          found_n = res_upd;
          state_n = DONE;
        end else begin
          res_n  = res_upd;
          idx_n  = idx_dec;
          cand_n = res_upd | (WIDTH'(1) << idx_dec);
          wait_n = WW'(CMP_LAT);
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.cand  = cand;
  assign bus.busy  = (state == PROBE);
  assign bus.done  = (state == DONE);
  assign bus.found = found;
  assign bus.err   = err;

endmodule
